// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bubble encoding, fetch FSM states and
// instruction field positions used by the decode-side controller.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    // sll $0,$0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        REQ     = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/flopenrc.sv
// Register with async active-high reset, load enable and a synchronous
// clear that loads a caller-supplied value instead of d.
module flopenrc #(
    parameter int unsigned     WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] clr_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = clr ? clr_val : d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/DEC pipeline register: owns the PC, drives the
// imem req/ready handshake and squashes stale fetches after a MEM redirect.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_DEC,
    input  logic        pcsrc_MEM,
    input  logic [31:0] pcbranch_MEM,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr_DEC,
    output logic [31:0] pcplus4_DEC,
    output logic        valid_DEC,
    output logic        fetch_wait
);

    localparam logic [31:0] WORD_MASK = ~32'h0000_0003;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;
    logic [31:0]  target;
    logic         xfer;
    logic         load_dec;
    logic         dec_en;
    logic [32:0]  dec_q;

    assign target = pcbranch_MEM & WORD_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC & WORD_MASK;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
        end
    end

    // A redirect only needs DISCARD when a request is actually on the bus
    // and has not completed; a stalled (dropped) request is simply retargeted.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        case (state_q)
            REQ: begin
                if (pcsrc_MEM) begin
                    pc_d = target;
                    if (imem_req && !xfer) begin
                        stale_d = pc_q;
                        state_d = DISCARD;
                    end
                end else if (xfer) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            DISCARD: begin
                if (xfer) begin
                    state_d = REQ;
                end
                if (pcsrc_MEM) begin
                    pc_d = target;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        imem_req   = !reset && ((state_q == REQ && !stall_DEC) || state_q == DISCARD);
        imem_addr  = (state_q == DISCARD) ? stale_q : pc_q;
        fetch_wait = !reset && (state_q == DISCARD || !imem_ready);
        xfer       = imem_req && imem_ready;
        load_dec   = (state_q == REQ) && xfer && !pcsrc_MEM;
        dec_en     = !stall_DEC || pcsrc_MEM;
    end

    // {valid, instr}: anything other than a fresh load becomes a bubble
    flopenrc #(
        .WIDTH  (33),
        .RST_VAL({1'b0, NOP_INSTR})
    ) u_dec_instr (
        .clk    (clk),
        .reset  (reset),
        .en     (dec_en),
        .clr    (!load_dec),
        .clr_val({1'b0, NOP_INSTR}),
        .d      ({1'b1, imem_rdata}),
        .q      (dec_q)
    );

    // pcplus4 keeps its last value across bubbles
    flopenrc #(
        .WIDTH  (32),
        .RST_VAL(32'h0000_0000)
    ) u_dec_pc4 (
        .clk    (clk),
        .reset  (reset),
        .en     (load_dec),
        .clr    (1'b0),
        .clr_val(32'h0000_0000),
        .d      (pc_q + 32'd4),
        .q      (pcplus4_DEC)
    );

    assign valid_DEC = dec_q[32];
    assign instr_DEC = dec_q[31:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, reset corner cases and a
// randomized run against a transaction-level fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_DEC;
    logic        pcsrc_MEM;
    logic [31:0] pcbranch_MEM;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr_DEC;
    logic [31:0] pcplus4_DEC;
    logic        valid_DEC;
    logic        fetch_wait;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall_DEC   (stall_DEC),
        .pcsrc_MEM   (pcsrc_MEM),
        .pcbranch_MEM(pcbranch_MEM),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr_DEC   (instr_DEC),
        .pcplus4_DEC (pcplus4_DEC),
        .valid_DEC   (valid_DEC),
        .fetch_wait  (fetch_wait)
    );

    // Address-tagged memory contents
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h5A00_0001;
    endfunction

    always_comb imem_rdata = imem_ready ? w(imem_addr) : 32'hBAD0_BAD0;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] br;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wait;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic stall, input logic pcsrc, input logic [31:0] br,
                                input logic ready, input logic e_req, input logic [31:0] e_addr,
                                input logic e_wait, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pp4);
        vec_t v;
        v.stall = stall; v.pcsrc = pcsrc; v.br = br; v.ready = ready;
        v.e_req = e_req; v.e_addr = e_addr; v.e_wait = e_wait;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pp4 = e_pp4;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_wait, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_pp4);
        chk({tag, ".imem_req"},    32'(imem_req),    32'(e_req));
        chk({tag, ".imem_addr"},   imem_addr,        e_addr);
        chk({tag, ".fetch_wait"},  32'(fetch_wait),  32'(e_wait));
        chk({tag, ".valid_DEC"},   32'(valid_DEC),   32'(e_valid));
        chk({tag, ".instr_DEC"},   instr_DEC,        e_instr);
        chk({tag, ".pcplus4_DEC"}, pcplus4_DEC,      e_pp4);
    endtask

    // Reference model: outstanding-fetch bookkeeping plus the DEC contents
    logic [31:0] m_pc, m_stale, m_instr, m_pp4;
    logic        m_disc, m_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_stale = 32'h0; m_disc = 1'b0;
        m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic stall, input logic pcsrc, input logic [31:0] br,
                              input logic ready);
        logic        req;
        logic        x;
        logic [31:0] tgt;
        req = m_disc ? 1'b1 : !stall;
        x   = req && ready;
        tgt = {br[31:2], 2'b00};
        if (pcsrc) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end else if (stall) begin
            // held
        end else if (!m_disc && x) begin
            m_valid = 1'b1; m_instr = w(m_pc); m_pp4 = m_pc + 32'd4;
        end else begin
            m_valid = 1'b0; m_instr = 32'h0;
        end
        if (m_disc) begin
            if (x) m_disc = 1'b0;
            if (pcsrc) m_pc = tgt;
        end else if (pcsrc) begin
            if (req && !x) begin
                m_disc  = 1'b1;
                m_stale = m_pc;
            end
            m_pc = tgt;
        end else if (x) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        reset = 1'b1; stall_DEC = 1'b0; pcsrc_MEM = 1'b0;
        pcbranch_MEM = 32'h0; imem_ready = 1'b0;

        // Directed sequence from reset release (one row per cycle)
        add(0,0,32'h0,       1, 1,32'h0,        0, 0,32'h0,          32'h0);
        add(0,0,32'h0,       1, 1,32'h4,        0, 1,w(32'h0),       32'h4);
        add(0,0,32'h0,       1, 1,32'h8,        0, 1,w(32'h4),       32'h8);
        add(0,0,32'h0,       1, 1,32'hC,        0, 1,w(32'h8),       32'hC);
        add(1,0,32'h0,       1, 0,32'h10,       0, 1,w(32'hC),       32'h10);
        add(1,0,32'h0,       1, 0,32'h10,       0, 1,w(32'hC),       32'h10);
        add(1,0,32'h0,       1, 0,32'h10,       0, 1,w(32'hC),       32'h10);
        add(0,0,32'h0,       1, 1,32'h10,       0, 1,w(32'hC),       32'h10);
        add(0,1,32'h400,     1, 1,32'h14,       0, 1,w(32'h10),      32'h14);
        add(0,0,32'h0,       1, 1,32'h400,      0, 0,32'h0,          32'h14);
        add(0,0,32'h0,       1, 1,32'h404,      0, 1,w(32'h400),     32'h404);
        add(0,1,32'h20,      1, 1,32'h408,      0, 1,w(32'h404),     32'h408);
        add(0,0,32'h0,       0, 1,32'h20,       1, 0,32'h0,          32'h408);
        add(0,1,32'h80,      0, 1,32'h20,       1, 0,32'h0,          32'h408);
        add(0,0,32'h0,       0, 1,32'h20,       1, 0,32'h0,          32'h408);
        add(0,0,32'h0,       1, 1,32'h20,       1, 0,32'h0,          32'h408);
        add(0,0,32'h0,       1, 1,32'h80,       0, 0,32'h0,          32'h408);
        add(1,1,32'h403,     1, 0,32'h84,       0, 1,w(32'h80),      32'h84);
        add(0,0,32'h0,       1, 1,32'h400,      0, 0,32'h0,          32'h84);
        add(0,1,32'hFFFFFFFC,1, 1,32'h404,      0, 1,w(32'h400),     32'h404);
        add(0,0,32'h0,       1, 1,32'hFFFFFFFC, 0, 0,32'h0,          32'h404);
        add(0,0,32'h0,       1, 1,32'h0,        0, 1,w(32'hFFFFFFFC),32'h0);
        add(0,1,32'h100,     0, 1,32'h4,        1, 1,w(32'h0),       32'h4);

        @(posedge clk); #1;
        chk_all("in_reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            stall_DEC    = vecs[i].stall;
            pcsrc_MEM    = vecs[i].pcsrc;
            pcbranch_MEM = vecs[i].br;
            imem_ready   = vecs[i].ready;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_wait,
                    vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pp4);
            @(posedge clk); #1;
        end

        // Now in DISCARD for stale 0x4 with pc=0x100: async reset mid-cycle
        stall_DEC = 1'b0; pcsrc_MEM = 1'b0; imem_ready = 1'b0;
        #1;
        chk_all("discard_pre", 1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h4);
        reset = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; imem_ready = 1'b1;
        #1;
        chk_all("post_rst", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("post_rst_load.instr", instr_DEC, w(32'h0));

        // Randomized run against the model
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] br;
            logic        st, ps, rd;
            st = ($urandom_range(0, 99) < 20);
            ps = ($urandom_range(0, 99) < 10);
            rd = ($urandom_range(0, 99) < 65);
            br = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 3)) : $urandom();
            stall_DEC = st; pcsrc_MEM = ps; pcbranch_MEM = br; imem_ready = rd;
            #1;
            chk_all($sformatf("rnd%0d", n), m_disc ? 1'b1 : !st, m_disc ? m_stale : m_pc,
                    m_disc || !rd, m_valid, m_instr, m_pp4);
            model_step(st, ps, br, rd);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
